// File: rtl/sigdel_pkg.sv
// Shared types and defaults for the sinc2 decimation sequencer.
package sigdel_pkg;

  localparam int DW_DEF     = 16;
  localparam int DIV_W_DEF  = 8;
  localparam int SETTLE_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2
  } seq_state_e;

endpackage

// File: rtl/sd_en_div.sv
// Terminal-count enable divider: pulses on the tick where the count equals tc_val.
module sd_en_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             tick,
  input  logic [DIV_W-1:0] tc_val,
  output logic             pulse
);

  logic [DIV_W-1:0] cnt;

  assign pulse = en & tick & (cnt == tc_val);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && tick) begin
      cnt <= pulse ? '0 : cnt + {{(DIV_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/sinc_seq_ctrl.sv
// Sinc2 filter sequencer: clock enables, start-up clear/settling discard and
// sample hand-off on valid/ready with a sticky overrun flag.
//
// state | meaning
// IDLE  | stopped, waiting for en; config latched on exit
// CLEAR | one-cycle synchronous filter clear
// RUN   | dividers running, decimated outputs captured
module sinc_seq_ctrl
  import sigdel_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int DIV_W  = DIV_W_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] fs_div,
  input  logic [DIV_W-1:0] osr,
  output logic             filt_clr_o,
  output logic             fsclk_o,
  output logic             fbwclk_o,
  input  logic [DW-1:0]    filt_in,
  output logic [DW-1:0]    sample_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             overrun_o,
  input  logic             clr_ovr_i,
  output logic             busy_o
);

  localparam logic [DIV_W-1:0] SETTLE_V = DIV_W'(SETTLE);

  seq_state_e       state, state_nxt;
  logic             latch_cfg;
  logic [DIV_W-1:0] fs_div_l, osr_l;
  logic [DIV_W-1:0] discard_cnt;
  logic             cap_q;
  logic             run_act;
  logic             keep;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fs_div_l <= '0;
      osr_l    <= '0;
    end else begin
      state <= state_nxt;
      if (latch_cfg) begin
        fs_div_l <= fs_div;
        osr_l    <= osr;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    latch_cfg  = 1'b0;
    filt_clr_o = 1'b0;
    unique case (state)
      IDLE: begin
        if (en) begin
          state_nxt = CLEAR;
          latch_cfg = 1'b1;
        end
      end
      CLEAR: begin
        filt_clr_o = 1'b1;
        state_nxt  = en ? RUN : IDLE;
      end
      RUN: begin
        if (!en) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy_o  = (state != IDLE);
  // en gates the enables combinationally so a stop takes effect this cycle
  assign run_act = (state == RUN) & en;

  sd_en_div #(.DIV_W(DIV_W)) u_fs_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (~run_act),
    .en     (run_act),
    .tick   (1'b1),
    .tc_val (fs_div_l),
    .pulse  (fsclk_o)
  );

  sd_en_div #(.DIV_W(DIV_W)) u_dec_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (~run_act),
    .en     (run_act),
    .tick   (fsclk_o),
    .tc_val (osr_l),
    .pulse  (fbwclk_o)
  );

  // filter output settles one cycle after its fbwclk update edge
  assign keep = cap_q & (discard_cnt >= SETTLE_V);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q       <= 1'b0;
      discard_cnt <= '0;
      sample_o    <= '0;
      valid_o     <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      cap_q <= fbwclk_o;

      if (state == CLEAR) begin
        discard_cnt <= '0;
      end else if (cap_q && (discard_cnt < SETTLE_V)) begin
        discard_cnt <= discard_cnt + {{(DIV_W-1){1'b0}}, 1'b1};
      end

      if (keep) begin
        sample_o <= filt_in;
        valid_o  <= 1'b1;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end

      if (keep && valid_o && !ready_i) begin
        overrun_o <= 1'b1;
      end else if (clr_ovr_i) begin
        overrun_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sinc_seq_ctrl.sv
// Directed bench for sinc_seq_ctrl: divider table plus multi-cycle corner sequences.
module tb_sinc_seq_ctrl;

  localparam int DW    = 16;
  localparam int DIV_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic [DIV_W-1:0] fs_div = '0;
  logic [DIV_W-1:0] osr = '0;
  logic             filt_clr_o, fsclk_o, fbwclk_o;
  logic [DW-1:0]    filt_in = '0;
  logic [DW-1:0]    sample_o;
  logic             valid_o, overrun_o, busy_o;
  logic             ready_i = 1'b0;
  logic             clr_ovr_i = 1'b0;

  int cyc;
  int n_pass = 0;
  int n_tot  = 0;

  sinc_seq_ctrl #(.DW(DW), .DIV_W(DIV_W), .SETTLE(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .fs_div     (fs_div),
    .osr        (osr),
    .filt_clr_o (filt_clr_o),
    .fsclk_o    (fsclk_o),
    .fbwclk_o   (fbwclk_o),
    .filt_in    (filt_in),
    .sample_o   (sample_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .overrun_o  (overrun_o),
    .clr_ovr_i  (clr_ovr_i),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    int fs;
    int osr;
    int fs1;
    int fs2;
    int fbw1;
    int fbw2;
    int vcyc;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) need %0d (0x%0h)", nm, act, act, exp, exp);
  endtask

  // cycle k is the interval after the k-th rising edge; filt_in = A000 + k
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    filt_in = 16'hA000 + 16'(cyc);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0;
    ready_i = 1'b0;
    clr_ovr_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic start(input int f, input int o);
    do_reset();
    fs_div = DIV_W'(f);
    osr = DIV_W'(o);
    cyc = -1;
    tick();
    en = 1'b1;
  endtask

  initial begin
    int f1, f2, b1, b2, v1, clr_c, clr_n, err_v, err_s, err_o, err_b, err_c;

    vecs[0] = '{fs:3, osr:3, fs1:5, fs2:9,  fbw1:17, fbw2:33, vcyc:51};
    vecs[1] = '{fs:0, osr:0, fs1:2, fs2:3,  fbw1:2,  fbw2:3,  vcyc:6};
    vecs[2] = '{fs:1, osr:2, fs1:3, fs2:5,  fbw1:7,  fbw2:13, vcyc:21};
    vecs[3] = '{fs:4, osr:0, fs1:6, fs2:11, fbw1:6,  fbw2:11, vcyc:18};
    vecs[4] = '{fs:0, osr:5, fs1:2, fs2:3,  fbw1:7,  fbw2:13, vcyc:21};

    #2;
    chk("reset_outputs", int'({sample_o, valid_o, overrun_o, filt_clr_o, fsclk_o, fbwclk_o, busy_o}), 0);

    // divider / settle table
    foreach (vecs[i]) begin
      start(vecs[i].fs, vecs[i].osr);
      f1 = -1; f2 = -1; b1 = -1; b2 = -1; v1 = -1; clr_c = -1; clr_n = 0;
      for (int c = 1; c <= vecs[i].vcyc; c++) begin
        tick();
        @(negedge clk);
        if (fsclk_o) begin
          if (f1 < 0) f1 = cyc; else if (f2 < 0) f2 = cyc;
        end
        if (fbwclk_o) begin
          if (b1 < 0) b1 = cyc; else if (b2 < 0) b2 = cyc;
        end
        if (filt_clr_o) begin
          clr_n++;
          clr_c = cyc;
        end
        if (valid_o && v1 < 0) v1 = cyc;
      end
      chk($sformatf("v%0d_clr_cycle", i), clr_c, 1);
      chk($sformatf("v%0d_clr_count", i), clr_n, 1);
      chk($sformatf("v%0d_fs1", i), f1, vecs[i].fs1);
      chk($sformatf("v%0d_fs2", i), f2, vecs[i].fs2);
      chk($sformatf("v%0d_fbw1", i), b1, vecs[i].fbw1);
      chk($sformatf("v%0d_fbw2", i), b2, vecs[i].fbw2);
      chk($sformatf("v%0d_first_valid", i), v1, vecs[i].vcyc);
      chk($sformatf("v%0d_sample", i), int'(sample_o), 'hA000 + vecs[i].vcyc - 1);
      chk($sformatf("v%0d_overrun", i), int'(overrun_o), 0);
      chk($sformatf("v%0d_busy", i), int'(busy_o), 1);
    end

    // asynchronous reset mid-RUN with a pending sample, checked between edges
    chk("pre_async_valid", int'(valid_o), 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", int'({sample_o, valid_o, overrun_o, filt_clr_o, fsclk_o, fbwclk_o, busy_o}), 0);

    // fs_div=0, osr=0, ready held: continuous stream, no overrun
    start(0, 0);
    ready_i = 1'b1;
    err_v = 0; err_s = 0; err_o = 0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      @(negedge clk);
      if (cyc >= 6) begin
        if (!valid_o) err_v++;
        if (int'(sample_o) != 'hA000 + cyc - 1) err_s++;
      end
      if (overrun_o) err_o++;
    end
    chk("stream_valid_gaps", err_v, 0);
    chk("stream_sample_errs", err_s, 0);
    chk("stream_overrun_cycles", err_o, 0);

    // same config, ready low: overrun set, clear only on a capture-free cycle
    start(0, 0);
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (cyc == 7) clr_ovr_i = 1'b1;
      if (cyc == 8) en = 1'b0;
      @(negedge clk);
      case (cyc)
        6: begin
          chk("ovr_c6_valid", int'(valid_o), 1);
          chk("ovr_c6_flag", int'(overrun_o), 0);
          chk("ovr_c6_sample", int'(sample_o), 'hA005);
        end
        7: begin
          chk("ovr_c7_flag", int'(overrun_o), 1);
          chk("ovr_c7_sample", int'(sample_o), 'hA006);
        end
        8: begin
          chk("ovr_c8_flag_kept", int'(overrun_o), 1);
          chk("ovr_c8_fsclk_gated", int'(fsclk_o), 0);
        end
        9: begin
          chk("ovr_c9_flag_kept", int'(overrun_o), 1);
          chk("ovr_c9_sample", int'(sample_o), 'hA008);
          chk("ovr_c9_busy", int'(busy_o), 0);
        end
        10: chk("ovr_c10_cleared", int'(overrun_o), 0);
        default: ;
      endcase
    end
    clr_ovr_i = 1'b0;

    // config change ignored in RUN; stop/restart keeps the pending sample
    start(3, 0);
    err_b = 0; err_c = 0; err_v = 0;
    for (int c = 1; c <= 48; c++) begin
      logic fbw_e, clr_e, val_e;
      tick();
      if (cyc == 3) fs_div = 8'd7;
      if (cyc == 18) en = 1'b0;
      if (cyc == 20) en = 1'b1;
      if (cyc == 47) ready_i = 1'b1;
      @(negedge clk);
      fbw_e = (cyc >= 5 && cyc <= 17 && (cyc - 5) % 4 == 0) ||
              (cyc >= 29 && (cyc - 29) % 8 == 0);
      clr_e = (cyc == 1) || (cyc == 21);
      val_e = (cyc >= 15) && (cyc <= 47);
      if (fbwclk_o != fbw_e) err_b++;
      if (filt_clr_o != clr_e) err_c++;
      if (valid_o != val_e) err_v++;
      if (cyc == 15) chk("rst_c15_sample", int'(sample_o), 'hA00E);
      if (cyc == 19) chk("rst_c19_overrun", int'(overrun_o), 1);
      if (cyc == 46) chk("rst_c46_pending_sample", int'(sample_o), 'hA012);
      if (cyc == 47) chk("rst_c47_new_sample", int'(sample_o), 'hA02E);
    end
    chk("restart_fbw_pattern_errs", err_b, 0);
    chk("restart_clr_pattern_errs", err_c, 0);
    chk("restart_valid_pattern_errs", err_v, 0);
    ready_i = 1'b0;

    // en dropped on the cycle fbwclk would fire
    start(1, 1);
    for (int c = 1; c <= 11; c++) begin
      tick();
      if (cyc == 9) en = 1'b0;
      @(negedge clk);
      if (cyc == 5) chk("stop_c5_fbw", int'(fbwclk_o), 1);
      if (cyc == 9) chk("stop_c9_enables", int'({fsclk_o, fbwclk_o}), 0);
      if (cyc == 10) chk("stop_c10_busy", int'(busy_o), 0);
      if (cyc == 11) chk("stop_c11_valid", int'(valid_o), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
